// File: rtl/dm_access_pkg.sv
// Shared types for the data-memory access controller: size encodings, FSM states
// and the alignment rule applied when a request is accepted.
package dm_access_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MRG,
    ST_WR,
    ST_RESP
  } state_e;

  // A request is rejected when the access would straddle a lane boundary or the size is unused.
  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response channel between the CPU datapath (master) and the access controller (slave).
interface dm_access_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: pulls a byte/half out of a memory word with extension,
// and splices store data into a memory word for read-modify-write.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] extract_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output and temporary gets a default before the case so no path infers a latch.
  always_comb begin
    byte_v    = 8'h00;
    half_v    = off_i[1] ? word_i[31:16] : word_i[15:0];
    extract_o = word_i;
    merge_o   = word_i;
    for (int k = 0; k < LANES; k++) begin
      if (off_i == k[1:0]) byte_v = word_i[8*k +: 8];
    end
    case (size_i)
      SZ_BYTE: begin
        extract_o = {{24{signed_i & byte_v[7]}}, byte_v};
        for (int k = 0; k < LANES; k++) begin
          if (off_i == k[1:0]) merge_o[8*k +: 8] = wdata_i[7:0];
        end
      end
      SZ_HALF: begin
        extract_o = {{16{signed_i & half_v[15]}}, half_v};
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        extract_o = word_i;
        merge_o   = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Byte-addressed load/store front end for the word-only DM: sub-word stores are
// done as read-modify-write, loads return aligned and extended data.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dm_access_ctrl_if.slave       bus,
  output logic                  dm_R,
  output logic                  dm_W,
  output logic [ADDR_WIDTH-1:0] dm_Addr,
  output logic [DATA_WIDTH-1:0] dm_W_data,
  input  logic [DATA_WIDTH-1:0] dm_R_data
);

  state_e                state_q, state_d;
  logic                  we_q, sgn_q, err_q;
  size_e                 size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH-1:0] ext_w, mrg_w;
  logic                  accept;
  logic                  req_bad;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign req_bad = misaligned(size_e'(bus.req_size), bus.req_addr[1:0]);

  dm_lane_align u_align (
    .word_i    (dm_R_data),
    .wdata_i   (wdata_q),
    .off_i     (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (sgn_q),
    .extract_o (ext_w),
    .merge_o   (mrg_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)                                           state_d = ST_RESP;
          else if (bus.req_we && (size_e'(bus.req_size) == SZ_WORD)) state_d = ST_WR;
          else                                                   state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_MRG;
      ST_MRG:  state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments; the DM strobes decode from state_q
  // alone, so reset drops them at once and an abandoned merge never reaches ST_WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        err_q   <= req_bad;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // Stores reuse wdata_q to hold the merged word for the write-back cycle.
      if (state_q == ST_MRG) begin
        if (we_q) wdata_q <= mrg_w;
        else      rdata_q <= ext_w;
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata = rdata_q;

  assign dm_R      = (state_q == ST_RD);
  assign dm_W      = (state_q == ST_WR);
  assign dm_Addr   = addr_q[ADDR_WIDTH+1:2];
  assign dm_W_data = wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: a driver pushes expected responses, a negedge
// monitor pops and compares them; a small DM model sits on the memory port.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dm_R, dm_W;
  logic [4:0]  dm_Addr;
  logic [31:0] dm_W_data;
  logic [31:0] dm_R_data;

  dm_access_ctrl_if #(.ADDR_WIDTH(5)) ifc ();

  dm_access_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .dm_R      (dm_R),
    .dm_W      (dm_W),
    .dm_Addr   (dm_Addr),
    .dm_W_data (dm_W_data),
    .dm_R_data (dm_R_data)
  );

  always #5 clk = ~clk;

  // DM model: one-cycle read latency, synchronous write, preloaded on the first edge.
  logic [31:0] mem [32];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1]     <= 32'h0000_9876;
      mem[2]     <= 32'h8000_7F01;
      dm_R_data  <= 32'h0;
      mem_loaded <= 1'b1;
    end else begin
      if (dm_R) dm_R_data <= mem[dm_Addr];
      if (dm_W) mem[dm_Addr] <= dm_W_data;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int r_cnt = 0, w_cnt = 0, both_cnt = 0;
  int exp_r = 0, exp_w = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (dm_R) r_cnt++;
    if (dm_W) w_cnt++;
    if (dm_R && dm_W) both_cnt++;
    if (rst_n && ifc.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_err"},   {31'h0, ifc.resp_err}, {31'h0, e.err});
        check({e.name, "_rdata"}, ifc.resp_rdata, e.rdata);
        check({e.name, "_lat"},   cyc, e.due);
      end
    end
  end

  // Called at a negedge; leaves req_valid high after the accept edge so requests can chain.
  task automatic issue(input string name, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [6:0] addr, input logic [31:0] wd, input logic err,
                       input logic [31:0] load_val);
    int n = 0;
    exp_t e;
    ifc.req_valid  = 1'b1;
    ifc.req_we     = we;
    ifc.req_size   = sz;
    ifc.req_signed = sgn;
    ifc.req_addr   = addr;
    ifc.req_wdata  = wd;
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.req_ready) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      e.name = name;
      e.err  = err;
      if (err) begin
        e.due = cyc + 1;
      end else if (!we) begin
        e.due = cyc + 3;
        last_rd = load_val;
        exp_r++;
      end else if (sz == 2'b10) begin
        e.due = cyc + 2;
        exp_w++;
      end else begin
        e.due = cyc + 4;
        exp_r++;
        exp_w++;
      end
      e.rdata = last_rd;
      exp_q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    ifc.req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic req(input string name, input logic we, input logic [1:0] sz, input logic sgn,
                     input logic [6:0] addr, input logic [31:0] wd, input logic err,
                     input logic [31:0] load_val);
    issue(name, we, sz, sgn, addr, wd, err, load_val);
    drain();
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_size   = 2'b00;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 7'h00;
    ifc.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'h0, ifc.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'h0, ifc.resp_err},   32'd0);
    check("rst_resp_rdata", ifc.resp_rdata,          32'd0);
    check("rst_dm_strobes", {30'h0, dm_R, dm_W},     32'd0);
    check("rst_req_ready",  {31'h0, ifc.req_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads from word1 = 0x00009876
    req("ld_w_04",   1'b0, 2'b10, 1'b0, 7'h04, 32'h0, 1'b0, 32'h0000_9876);
    req("ld_bs_05",  1'b0, 2'b00, 1'b1, 7'h05, 32'h0, 1'b0, 32'hFFFF_FF98);
    req("ld_bu_05",  1'b0, 2'b00, 1'b0, 7'h05, 32'h0, 1'b0, 32'h0000_0098);
    req("ld_hs_04",  1'b0, 2'b01, 1'b1, 7'h04, 32'h0, 1'b0, 32'hFFFF_9876);

    // Byte store via read-modify-write, then read back
    req("st_b_06",   1'b1, 2'b00, 1'b0, 7'h06, 32'h0000_00AB, 1'b0, 32'h0);
    check("mem_word1_after_sb", mem[1], 32'h00AB_9876);
    req("ld_w_04b",  1'b0, 2'b10, 1'b0, 7'h04, 32'h0, 1'b0, 32'h00AB_9876);

    // Rejected requests: no DM access, rdata held
    req("err_sh_03", 1'b1, 2'b01, 1'b0, 7'h03, 32'h0000_5555, 1'b1, 32'h0);
    req("err_sz11",  1'b0, 2'b11, 1'b0, 7'h08, 32'h0, 1'b1, 32'h0);
    req("err_sw_0a", 1'b1, 2'b10, 1'b0, 7'h0A, 32'h1111_2222, 1'b1, 32'h0);
    check("mem_word0_after_err", mem[0], 32'h0);
    check("mem_word1_after_err", mem[1], 32'h00AB_9876);

    // Upper lanes of word2 = 0x80007F01
    req("ld_hu_0a",  1'b0, 2'b01, 1'b0, 7'h0A, 32'h0, 1'b0, 32'h0000_8000);
    req("ld_hs_0a",  1'b0, 2'b01, 1'b1, 7'h0A, 32'h0, 1'b0, 32'hFFFF_8000);
    req("ld_bs_09",  1'b0, 2'b00, 1'b1, 7'h09, 32'h0, 1'b0, 32'h0000_007F);
    req("st_h_0a",   1'b1, 2'b01, 1'b0, 7'h0A, 32'hFFFF_1234, 1'b0, 32'h0);
    check("mem_word2_after_sh", mem[2], 32'h1234_7F01);
    req("ld_w_08",   1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 1'b0, 32'h1234_7F01);

    // Reset while a byte store sits in MRG: no write may follow
    ifc.req_valid  = 1'b1;
    ifc.req_we     = 1'b1;
    ifc.req_size   = 2'b00;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 7'h04;
    ifc.req_wdata  = 32'h0000_00CD;
    check("rmw_rst_ready_before", {31'h0, ifc.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    exp_r++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_dm_strobes", {30'h0, dm_R, dm_W},  32'd0);
    check("rmw_rst_resp_valid", {31'h0, ifc.resp_valid}, 32'd0);
    check("rmw_rst_resp_rdata", ifc.resp_rdata,        32'd0);
    check("rmw_rst_resp_err",   {31'h0, ifc.resp_err}, 32'd0);
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_rst_ready_after", {31'h0, ifc.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("mem_word1_after_rst", mem[1], 32'h00AB_9876);
    req("ld_w_04c",  1'b0, 2'b10, 1'b0, 7'h04, 32'h0, 1'b0, 32'h00AB_9876);

    // req_valid held high across three chained requests
    issue("b2b_ld_08", 1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 1'b0, 32'h1234_7F01);
    issue("b2b_sw_0c", 1'b1, 2'b10, 1'b0, 7'h0C, 32'hDEAD_BEEF, 1'b0, 32'h0);
    issue("b2b_ld_0c", 1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, 1'b0, 32'hDEAD_BEEF);
    drain();
    check("mem_word3_after_b2b", mem[3], 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    check("dm_R_cycles",    r_cnt,    exp_r);
    check("dm_W_cycles",    w_cnt,    exp_w);
    check("dm_R_W_overlap", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
